// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial MSB-first bit-pattern transmitter with repeat count
//
// Latches an up-to-W-bit pattern on start and shifts it out MSB-first, one bit
// per clock, repeated reps times (0 counts as 1). All outputs are registered.
//
// Optional feature macro: GEN_GAP_EN
//   defined   : GAP idle cycles (o_valid=0, busy=1) between repetitions (GAP >= 1)
//   undefined : repetitions are sent back-to-back, no GAP state or counter
//
// Ports:
//   clk      in   rising-edge clock
//   resetn   in   asynchronous active-low reset
//   start    in   transfer request, sampled only in IDLE
//   pattern  in   W   bits to send; bit len-1 goes out first
//   len      in   LW  bits per repetition; 0 legal, values > W clamp to W
//   reps     in   CW  repetition count; 0 treated as 1
//   abort    in   synchronous cancel, honoured in SHIFT/GAP
//   o        out  serial data bit
//   o_valid  out  o carries a pattern bit this cycle
//   busy     out  transfer in progress
//   done     out  one-cycle completion pulse

module seq_pattern_gen #(
   parameter int W   = 8,
   parameter int LW  = 4,
   parameter int CW  = 4,
   parameter int GAP = 2
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   input  logic [W-1:0]  pattern,
   input  logic [LW-1:0] len,
   input  logic [CW-1:0] reps,
   input  logic          abort,
   output logic          o,
   output logic          o_valid,
   output logic          busy,
   output logic          done
);

   localparam logic [LW-1:0] W_L  = LW'(W);
   localparam logic [LW-1:0] ONE_L = LW'(1);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
`ifdef GEN_GAP_EN
      S_GAP   = 2'd2,
`endif
      S_FIN   = 2'd3
   } state_t;

`ifdef GEN_GAP_EN
   localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
   logic [GW-1:0] r_gap_cnt;
`endif

   state_t        r_state;
   logic [W-1:0]  r_pat;      // latched pattern, left-aligned so the first bit sits at MSB
   logic [W-1:0]  r_shift;    // bits still to be sent after the one currently on o
   logic [LW-1:0] r_len;
   logic [LW-1:0] r_bit_cnt;  // bits left in this repetition, including the one on o
   logic [CW-1:0] r_rep_cnt;  // repetitions left, including the current one
   logic          r_o;
   logic          r_o_valid;
   logic          r_busy;
   logic          r_done;

   logic [LW-1:0] w_len_eff;
   logic [CW-1:0] w_reps_eff;
   logic [W-1:0]  w_aligned;

   assign w_len_eff  = (len > W_L) ? W_L : len;
   assign w_reps_eff = (reps == '0) ? ONE_C : reps;
   // Left-align so bit len_eff-1 of the input lands on the MSB.
   assign w_aligned  = pattern << (W_L - w_len_eff);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_pat     <= '0;
         r_shift   <= '0;
         r_len     <= '0;
         r_bit_cnt <= '0;
         r_rep_cnt <= '0;
         r_o       <= 1'b0;
         r_o_valid <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
`ifdef GEN_GAP_EN
         r_gap_cnt <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_pat     <= w_aligned;
                  r_len     <= w_len_eff;
                  r_rep_cnt <= w_reps_eff;
                  if (w_len_eff == '0) begin
                     r_state   <= S_FIN;
                     r_done    <= 1'b1;
                     r_busy    <= 1'b0;
                     r_o_valid <= 1'b0;
                     r_o       <= 1'b0;
                  end else begin
                     r_state   <= S_SHIFT;
                     r_o       <= w_aligned[W-1];
                     r_shift   <= w_aligned << 1;
                     r_bit_cnt <= w_len_eff;
                     r_o_valid <= 1'b1;
                     r_busy    <= 1'b1;
                  end
               end
            end

            S_SHIFT: begin
               if (abort) begin
                  r_state   <= S_IDLE;
                  r_o       <= 1'b0;
                  r_o_valid <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b0;
               end else if (r_bit_cnt > ONE_L) begin
                  r_o       <= r_shift[W-1];
                  r_shift   <= r_shift << 1;
                  r_bit_cnt <= r_bit_cnt - ONE_L;
               end else if (r_rep_cnt > ONE_C) begin
                  r_rep_cnt <= r_rep_cnt - ONE_C;
`ifdef GEN_GAP_EN
                  r_state   <= S_GAP;
                  r_gap_cnt <= GW'(GAP);
                  r_o       <= 1'b0;
                  r_o_valid <= 1'b0;
`else
                  r_o       <= r_pat[W-1];
                  r_shift   <= r_pat << 1;
                  r_bit_cnt <= r_len;
`endif
               end else begin
                  r_state   <= S_FIN;
                  r_o       <= 1'b0;
                  r_o_valid <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
               end
            end

`ifdef GEN_GAP_EN
            S_GAP: begin
               if (abort) begin
                  r_state   <= S_IDLE;
                  r_o       <= 1'b0;
                  r_o_valid <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b0;
               end else if (r_gap_cnt > GW'(1)) begin
                  r_gap_cnt <= r_gap_cnt - GW'(1);
               end else begin
                  r_state   <= S_SHIFT;
                  r_o       <= r_pat[W-1];
                  r_shift   <= r_pat << 1;
                  r_bit_cnt <= r_len;
                  r_o_valid <= 1'b1;
               end
            end
`endif

            S_FIN: begin
               // start is deliberately not sampled here; a held start re-triggers from IDLE.
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end

            default: begin
               r_state   <= S_IDLE;
               r_o       <= 1'b0;
               r_o_valid <= 1'b0;
               r_busy    <= 1'b0;
               r_done    <= 1'b0;
            end
         endcase
      end
   end

   assign o       = r_o;
   assign o_valid = r_o_valid;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - self-checking bench for seq_pattern_gen

module tb_seq_pattern_gen;

   localparam int W     = 8;
   localparam int LW    = 4;
   localparam int CW    = 4;
   localparam int GAP_C = 2;

   logic          clk = 1'b0;
   logic          resetn;
   logic          start;
   logic [W-1:0]  pattern;
   logic [LW-1:0] len;
   logic [CW-1:0] reps;
   logic          abort;
   logic          o, o_valid, busy, done;

   int checks = 0;
   int errors = 0;

   // Expected per-cycle outputs {o, o_valid, busy, done}, starting the cycle after the start edge.
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   seq_pattern_gen #(.W(W), .LW(LW), .CW(CW), .GAP(GAP_C)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .start   (start),
      .pattern (pattern),
      .len     (len),
      .reps    (reps),
      .abort   (abort),
      .o       (o),
      .o_valid (o_valid),
      .busy    (busy),
      .done    (done)
   );

   // Reference: the stream is the low len_eff bits MSB-first, repeated reps_eff
   // times (with idle gaps in between when the gap feature is built), then a done cycle.
   task automatic build(input logic [W-1:0] pat, input int ln, input int rp);
      int le, re;
      exp_q.delete();
      le = (ln > W) ? W : ln;
      re = (rp == 0) ? 1 : rp;
      if (le > 0) begin
         for (int r = 0; r < re; r++) begin
            for (int k = 0; k < le; k++)
               exp_q.push_back({pat[le-1-k], 1'b1, 1'b1, 1'b0});
`ifdef GEN_GAP_EN
            if (r < re - 1)
               for (int g = 0; g < GAP_C; g++)
                  exp_q.push_back(4'b0010);
`endif
         end
      end
      exp_q.push_back(4'b0001);
   endtask

   // Called at posedge+1 while the DUT is idle; ends at posedge+1 in idle.
   task automatic run_xfer(input string name, input logic [W-1:0] pat, input logic [LW-1:0] ln,
                           input logic [CW-1:0] rp, input int abort_at, input bit noise,
                           input bit abort_on_start);
      logic [3:0] got;
      int dones;
      build(pat, int'(ln), int'(rp));
      if (abort_at >= 0)
         while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
      exp_q.push_back(4'b0000);
      pattern = pat; len = ln; reps = rp; start = 1'b1; abort = abort_on_start;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      dones = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         got = {o, o_valid, busy, done};
         dones += int'(done);
         checks++;
         if (got !== exp_q[i]) begin
            errors++;
            $display("FAIL %s cyc %0d got o/v/busy/done=%b exp %b", name, i + 1, got, exp_q[i]);
         end
         abort = (i == abort_at);
         start = 1'b0;
         if (noise && i < exp_q.size() - 1) begin
            start   = 1'($urandom);
            pattern = W'($urandom);
            len     = LW'($urandom);
            reps    = CW'($urandom);
            if (exp_q[i][0]) abort = 1'($urandom);
         end
         if (i < exp_q.size() - 1) begin
            @(posedge clk); #1;
         end
      end
      abort = 1'b0; start = 1'b0;
      checks++;
      if (dones !== ((abort_at >= 0) ? 0 : 1)) begin
         errors++;
         $display("FAIL %s done_count got %0d exp %0d", name, dones, (abort_at >= 0) ? 0 : 1);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; start = 1'b0; abort = 1'b0; pattern = '0; len = '0; reps = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({o, o_valid, busy, done} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_state got %b exp 0000", {o, o_valid, busy, done});
      end
      resetn = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({o, o_valid, busy, done} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle got %b exp 0000", {o, o_valid, busy, done});
      end
   endtask

   task automatic test_directed();
      run_xfer("p101_x1",   8'b0000_0101, 4'd3,  4'd1, -1, 1'b0, 1'b0);
      run_xfer("p101_x3",   8'b0000_0101, 4'd3,  4'd3, -1, 1'b0, 1'b0);
      run_xfer("len0_x5",   8'hFF,        4'd0,  4'd5, -1, 1'b0, 1'b0);
      run_xfer("clamp",     8'hC3,        4'd12, 4'd0, -1, 1'b1, 1'b0);
      run_xfer("full_x2",   8'h96,        4'd8,  4'd2, -1, 1'b1, 1'b0);
      run_xfer("len1_x4",   8'h01,        4'd1,  4'd4, -1, 1'b0, 1'b0);
   endtask

   task automatic test_abort();
      run_xfer("abort_bit4", 8'hA5, 4'd8, 4'd2, 3, 1'b0, 1'b0);
      run_xfer("after_abort", 8'hA5, 4'd8, 4'd1, -1, 1'b0, 1'b0);
      // Abort coinciding with the very last bit wins over completion.
      run_xfer("abort_last", 8'h5A, 4'd4, 4'd2, 7, 1'b0, 1'b0);
`ifdef GEN_GAP_EN
      run_xfer("abort_gap", 8'h05, 4'd3, 4'd3, 3, 1'b0, 1'b0);
`endif
      run_xfer("start_abort_idle", 8'h0B, 4'd4, 4'd1, -1, 1'b0, 1'b1);
   endtask

   task automatic test_async_reset();
      pattern = 8'hA5; len = 4'd8; reps = 4'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      checks++;
      if ({o, o_valid, busy, done} !== 4'b0000) begin
         errors++;
         $display("FAIL async_reset got %b exp 0000", {o, o_valid, busy, done});
      end
      #4 resetn = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({o, o_valid, busy, done} !== 4'b0000) begin
         errors++;
         $display("FAIL post_reset got %b exp 0000", {o, o_valid, busy, done});
      end
      run_xfer("fresh_after_reset", 8'h6D, 4'd7, 4'd2, -1, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [3:0] seq[$];
      logic [3:0] got;
      int split;
      build(8'h0D, 4, 2);
      seq = exp_q;
      split = seq.size();
      exp_q.delete();
      foreach (seq[j]) exp_q.push_back(seq[j]);
      exp_q.push_back(4'b0000);
      foreach (seq[j]) exp_q.push_back(seq[j]);
      exp_q.push_back(4'b0000);
      pattern = 8'h0D; len = 4'd4; reps = 4'd2; start = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < exp_q.size(); i++) begin
         got = {o, o_valid, busy, done};
         checks++;
         if (got !== exp_q[i]) begin
            errors++;
            $display("FAIL held_start cyc %0d got %b exp %b", i + 1, got, exp_q[i]);
         end
         if (i == split + 1) start = 1'b0;
         if (i < exp_q.size() - 1) begin
            @(posedge clk); #1;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_random();
      int ab;
      int busy_idx[$];
      for (int t = 0; t < 40; t++) begin
         logic [W-1:0]  p;
         logic [LW-1:0] l;
         logic [CW-1:0] r;
         p = W'($urandom);
         l = LW'($urandom);
         r = CW'($urandom_range(0, 5));
         ab = -1;
         if ($urandom_range(0, 3) == 0) begin
            build(p, int'(l), int'(r));
            busy_idx.delete();
            foreach (exp_q[j]) if (exp_q[j][1]) busy_idx.push_back(j);
            if (busy_idx.size() > 0)
               ab = busy_idx[$urandom_range(0, busy_idx.size() - 1)];
         end
         run_xfer($sformatf("rand%0d", t), p, l, r, ab, 1'b1, 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_abort();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial bit-pattern transmitter: latches an up-to-W-bit pattern and emits it MSB-first, one bit per clock, repeated a programmable number of times.
- Drives stimulus into the team's serial sequence detectors (e.g. "101" Mealy detectors). It is the transmit end of the single-bit serial stream those blocks receive.
- Start/busy/done handshake to a controlling FSM or testbench.

Parameters:
- W, 8, maximum pattern width in bits.
- LW, 4, width of len port; must satisfy 2^LW > W.
- CW, 4, width of repeat-count port.
- GAP, 2, idle cycles between repetitions. Used only with GEN_GAP_EN.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- pattern  input  W  bits to send; bit len-1 is sent first.
- len  input  LW  number of bits per repetition; 0 is legal; values > W are clamped to W.
- reps  input  CW  repetition count; 0 is treated as 1.
- abort  input  1  synchronous cancel.
- o  output  1  serial data bit.
- o_valid  output  1  o carries a pattern bit this cycle.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: resetn=0 asynchronously forces state=IDLE and o=0, o_valid=0, busy=0, done=0. It also clears the shift register and all counters. Reset is legal mid-transfer; no done is issued.
- All outputs are registered; there is no combinational input-to-output path.
- FSM states: IDLE, SHIFT, GAP (exists only with GEN_GAP_EN), FIN.
- IDLE:
  - On posedge with start=1: latch pattern, len_eff=min(len,W), and reps_eff=(reps==0)?1:reps.
  - If len_eff==0, go to FIN. Otherwise go to SHIFT.
- SHIFT: for len_eff consecutive cycles, o=pattern[len_eff-1-k] for k=0..len_eff-1, with o_valid=1 and busy=1.
  - First bit appears in the cycle after the start edge (latency 1).
  - After the last bit of a repetition:
    - If reps remain: reload the shift register from the latched copy and continue. Without GEN_GAP_EN the next repetition follows back-to-back; with it, go to GAP.
    - Otherwise go to FIN.
- FIN: done=1, busy=0, o_valid=0, o=0 for exactly one cycle, then IDLE.
- Start handling:
  - start is ignored in SHIFT, GAP and FIN; it is not queued.
  - start held high continuously re-triggers on the first IDLE cycle after FIN.
- Input stability: pattern, len and reps are don't-care except at the accepting edge. Changes mid-transfer have no effect.
- abort=1 at a posedge in SHIFT or GAP: next cycle state=IDLE, o_valid=0, busy=0, done=0. abort in IDLE or FIN is ignored.
- Simultaneous events:
  - abort together with the last bit: abort wins, no FIN.
  - start together with abort in IDLE: start is accepted (abort is ignored in IDLE).
- Counters:
  - Bit counter is LW bits and counts down from len_eff.
  - Repeat counter is CW bits and counts down from reps_eff; no wrap-around is possible.
  - Total valid bits per transfer = len_eff*reps_eff.

Optional Feature:
- Macro: GEN_GAP_EN.
- Defined: between repetitions (never after the last one) the FSM spends GAP cycles in GAP with o=0, o_valid=0, busy=1. abort is honoured in GAP.
- Undefined: GAP state and its counter are not compiled; repetitions are strictly back-to-back.

Test Plan:
1. pattern=8'b0000_0101, len=3, reps=1, pulse start:
   - Cycles 1-3 after the start edge: o=1,0,1 with o_valid=1, busy=1.
   - Cycle 4: done=1, busy=0.
   - Cycle 5: IDLE; a 101 detector fed o/o_valid fires once.
2. pattern=8'b101, len=3, reps=3, macro off:
   - Nine consecutive valid bits 101101101, then done in cycle 10.
   - Macro on with GAP=2: 101,00(invalid),101,00(invalid),101; done in cycle 14.
3. len=0, reps=5, start:
   - o_valid never asserts; done=1 in cycle 1 after start; busy stays 0.
4. pattern=8'hA5, len=8, reps=2; assert abort at bit 4 of repetition 1:
   - o_valid drops the next cycle; done never pulses; a new start afterwards sends 10100101 normally.
5. resetn driven low for 0.5 cycle mid-SHIFT (between clock edges):
   - All outputs go to 0 immediately, without waiting for a clock edge.
   - After release, start launches a fresh transfer with latency 1.
6. reps=0 and len=12 with W=8:
   - Treated as reps=1, len=8; exactly 8 valid bits.
   - A start pulse issued while busy is ignored: only one done.
